mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mano_pkg.sv | 22 ++
 rtl/mem_responder_mem_array.sv | 39 +++
 rtl/mem_responder.sv | 139 +++++++++++++
 tb/tb_mem_responder.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/mano_pkg.sv
// Shared types and constants for the memory responder slice: FSM state
// encoding, default widths and the wait-state limit.
package mano_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WAIT   = 3'd1,
    S_ACCESS = 3'd2,
    S_DONE   = 3'd3,
    S_REARM  = 3'd4
  } state_t;

  localparam int DW_DEF   = 8;
  localparam int AW_DEF   = 8;
  localparam int WAIT_MAX = 15;

  // A request is legal only when exactly one strobe is raised.
  function automatic logic single_strobe(input logic rd, input logic wr);
    return rd ^ wr;
  endfunction

endpackage

// File: rtl/mem_responder_mem_array.sv
// Single-port 2^AW x DW storage: synchronous write, registered read port.
// Reset only clears the read register; array contents survive reset.
module mem_array
  import mano_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_r [0:(1<<AW)-1];
  logic [DW-1:0] rdata_r;

  // Storage write port, no reset so the array maps onto RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[addr] <= wdata;
    end
  end

  // Read register holds its value until the next enabled read.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_r <= '0;
    end else if (re) begin
      rdata_r <= mem_r[addr];
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/mem_responder.sv
// Wait-stated memory responder for a Mano-style control unit: latches one
// request, counts wait states, performs the access and pulses RDY.
module mem_responder
  import mano_pkg::*;
#(
  parameter int DW          = DW_DEF,
  parameter int AW          = AW_DEF,
  parameter int WAIT_STATES = 2
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          READ,
  input  logic          WRITE,
  input  logic [AW-1:0] ADDR,
  input  logic [DW-1:0] WDATA,
  output logic [DW-1:0] RDATA,
  output logic          RDY,
  output logic          BUSY,
  output logic          HOLD,
  output logic          ERR
);

  localparam logic [3:0] WS_LOAD = 4'(WAIT_STATES);

  state_t        state_r;
  logic [3:0]    cnt_r;
  logic [AW-1:0] addr_r;
  logic [DW-1:0] wdata_r;
  logic          wr_r;
  logic          rdy_r;
  logic          busy_r;
  logic          err_r;
  logic          hold_s;
  logic          mem_we_s;
  logic          mem_re_s;

  // Request FSM with wait counter, latched operation and registered flags.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r <= S_IDLE;
      cnt_r   <= 4'd0;
      addr_r  <= '0;
      wdata_r <= '0;
      wr_r    <= 1'b0;
      rdy_r   <= 1'b0;
      busy_r  <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          rdy_r <= 1'b0;
          if (single_strobe(READ, WRITE)) begin
            addr_r  <= ADDR;
            wdata_r <= WDATA;
            wr_r    <= WRITE;
            err_r   <= 1'b0;
            busy_r  <= 1'b1;
            if (WAIT_STATES == 0) begin
              state_r <= S_ACCESS;
              cnt_r   <= 4'd0;
            end else begin
              state_r <= S_WAIT;
              cnt_r   <= WS_LOAD;
            end
          end else if (READ && WRITE) begin
            // Conflicting strobes: flag it and wait for both to drop.
            err_r   <= 1'b1;
            state_r <= S_REARM;
          end else begin
            state_r <= S_IDLE;
          end
        end
        S_WAIT: begin
          if (cnt_r <= 4'd1) begin
            cnt_r   <= 4'd0;
            state_r <= S_ACCESS;
          end else begin
            cnt_r   <= cnt_r - 4'd1;
          end
        end
        S_ACCESS: begin
          busy_r  <= 1'b0;
          rdy_r   <= 1'b1;
          state_r <= S_DONE;
        end
        S_DONE: begin
          rdy_r   <= 1'b0;
          state_r <= (READ || WRITE) ? S_REARM : S_IDLE;
        end
        S_REARM: begin
          if (!READ && !WRITE) begin
            state_r <= S_IDLE;
          end else begin
            state_r <= S_REARM;
          end
        end
        default: begin
          state_r <= S_IDLE;
          cnt_r   <= 4'd0;
          rdy_r   <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  // HOLD must rise in the same cycle a request is presented.
  always_comb begin
    hold_s = 1'b0;
    case (state_r)
      S_WAIT, S_ACCESS: hold_s = 1'b1;
      S_IDLE:           hold_s = single_strobe(READ, WRITE) & ~RST;
      default:          hold_s = 1'b0;
    endcase
  end

  // Reset in the ACCESS cycle wins, so gate both enables with RST.
  assign mem_we_s = (state_r == S_ACCESS) &  wr_r & ~RST;
  assign mem_re_s = (state_r == S_ACCESS) & ~wr_r & ~RST;

  mem_array #(
    .DW (DW),
    .AW (AW)
  ) u_mem (
    .clk   (CLK),
    .rst   (RST),
    .we    (mem_we_s),
    .re    (mem_re_s),
    .addr  (addr_r),
    .wdata (wdata_r),
    .rdata (RDATA)
  );

  assign RDY  = rdy_r;
  assign BUSY = busy_r;
  assign ERR  = err_r;
  assign HOLD = hold_s;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench: instance a uses WAIT_STATES=2, instance b WAIT_STATES=0.
// Stimulus pushes expected completions; a negedge monitor pops and compares.
module tb_mem_responder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rd_a = 1'b0, wr_a = 1'b0, rd_b = 1'b0, wr_b = 1'b0;
  logic [7:0] ad_a = 8'd0, wd_a = 8'd0, ad_b = 8'd0, wd_b = 8'd0;
  logic [7:0] rdata_a, rdata_b;
  logic       rdy_a, busy_a, hold_a, err_a;
  logic       rdy_b, busy_b, hold_b, err_b;

  int nvec  = 0;
  int nfail = 0;
  int cyc   = 0;

  typedef struct {
    int         cyc;
    bit         rd;
    logic [7:0] data;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  mem_responder #(.DW(8), .AW(8), .WAIT_STATES(2)) dut_a (
    .CLK(clk), .RST(rst), .READ(rd_a), .WRITE(wr_a), .ADDR(ad_a), .WDATA(wd_a),
    .RDATA(rdata_a), .RDY(rdy_a), .BUSY(busy_a), .HOLD(hold_a), .ERR(err_a)
  );

  mem_responder #(.DW(8), .AW(8), .WAIT_STATES(0)) dut_b (
    .CLK(clk), .RST(rst), .READ(rd_b), .WRITE(wr_b), .ADDR(ad_b), .WDATA(wd_b),
    .RDATA(rdata_b), .RDY(rdy_b), .BUSY(busy_b), .HOLD(hold_b), .ERR(err_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every RDY must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rdy_a === 1'b1) begin
      if (q_a.size() == 0) begin
        chk("spurious_rdy_a", {31'd0, rdy_a}, 32'd0);
      end else begin
        e = q_a.pop_front();
        chk("latency_a", cyc, e.cyc);
        if (e.rd) chk("rdata_a", {24'd0, rdata_a}, {24'd0, e.data});
      end
    end
    if (rdy_b === 1'b1) begin
      if (q_b.size() == 0) begin
        chk("spurious_rdy_b", {31'd0, rdy_b}, 32'd0);
      end else begin
        e = q_b.pop_front();
        chk("latency_b", cyc, e.cyc);
        if (e.rd) chk("rdata_b", {24'd0, rdata_b}, {24'd0, e.data});
      end
    end
  end

  task automatic drive(input bit b, input bit r, input bit w, input logic [7:0] ad, input logic [7:0] wd);
    if (b) begin rd_b = r; wr_b = w; ad_b = ad; wd_b = wd; end
    else   begin rd_a = r; wr_a = w; ad_a = ad; wd_a = wd; end
  endtask

  task automatic drop(input bit b);
    if (b) begin rd_b = 1'b0; wr_b = 1'b0; end
    else   begin rd_a = 1'b0; wr_a = 1'b0; end
  endtask

  task automatic expect_done(input bit b, input bit r, input logic [7:0] d);
    exp_t e;
    e.rd   = r;
    e.data = d;
    e.cyc  = cyc + (b ? 2 : 4);
    if (b) q_b.push_back(e); else q_a.push_back(e);
  endtask

  // One complete request: strobe for a single cycle, then wait for completion.
  task automatic req(input bit b, input bit r, input logic [7:0] ad, input logic [7:0] wd, input logic [7:0] expd);
    @(posedge clk); #1;
    drive(b, r, ~r, ad, wd);
    expect_done(b, r, expd);
    @(posedge clk); #1;
    drop(b);
    repeat (5) @(posedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rdata_a", {24'd0, rdata_a}, 32'd0);
    chk("rst_rdy_a",   {31'd0, rdy_a},   32'd0);
    chk("rst_busy_a",  {31'd0, busy_a},  32'd0);
    chk("rst_err_a",   {31'd0, err_a},   32'd0);
    chk("rst_hold_a",  {31'd0, hold_a},  32'd0);
    chk("rst_busy_b",  {31'd0, busy_b},  32'd0);
    // A request while reset is held must not be accepted.
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b1, 8'h3C, 8'hEE);
    @(negedge clk);
    chk("rst_hold_block", {31'd0, hold_a}, 32'd0);
    @(posedge clk); #1;
    drop(1'b0);
    chk("rst_busy_block", {31'd0, busy_a}, 32'd0);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // Write 0x3C<=0xA5 with HOLD/BUSY profile over the five-cycle access.
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b1, 8'h3C, 8'hA5);
    expect_done(1'b0, 1'b0, 8'h00);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("hold_a_c%0d", k), {31'd0, hold_a}, {31'd0, (k < 4)});
      chk($sformatf("busy_a_c%0d", k), {31'd0, busy_a}, {31'd0, (k >= 1 && k <= 3)});
      @(posedge clk); #1;
      if (k == 0) drop(1'b0);
    end
    repeat (2) @(posedge clk);
    req(1'b0, 1'b1, 8'h3C, 8'h00, 8'hA5);

    // Zero wait states: BUSY only in the ACCESS cycle, RDY two cycles later.
    req(1'b1, 1'b0, 8'h3C, 8'hA5, 8'h00);
    @(posedge clk); #1;
    drive(1'b1, 1'b1, 1'b0, 8'h3C, 8'h00);
    expect_done(1'b1, 1'b1, 8'hA5);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("busy_b_c%0d", k), {31'd0, busy_b}, {31'd0, (k == 1)});
      chk($sformatf("rdy_b_c%0d", k),  {31'd0, rdy_b},  {31'd0, (k == 2)});
      @(posedge clk); #1;
      if (k == 0) drop(1'b1);
    end
    repeat (2) @(posedge clk);

    // Both strobes high: error, no access, content unchanged.
    req(1'b0, 1'b0, 8'h10, 8'h00, 8'h00);
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 1'b1, 8'h10, 8'hFF);
    @(negedge clk);
    chk("both_hold", {31'd0, hold_a}, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("both_err",  {31'd0, err_a},  32'd1);
    chk("both_busy", {31'd0, busy_a}, 32'd0);
    @(posedge clk); #1;
    drop(1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("err_sticky", {31'd0, err_a}, 32'd1);
    req(1'b0, 1'b1, 8'h10, 8'h00, 8'h00);
    @(negedge clk);
    chk("err_cleared", {31'd0, err_a}, 32'd0);

    // Strobe held past RDY: REARM blocks a second access.
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b1, 8'h20, 8'h5A);
    expect_done(1'b0, 1'b0, 8'h00);
    repeat (4) @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk($sformatf("rearm_hold_%0d", k), {31'd0, hold_a}, 32'd0);
      chk($sformatf("rearm_busy_%0d", k), {31'd0, busy_a}, 32'd0);
    end
    @(posedge clk); #1;
    drop(1'b0);
    req(1'b0, 1'b1, 8'h20, 8'h00, 8'h5A);

    // Reset during the first WAIT cycle aborts the write.
    req(1'b0, 1'b0, 8'hFF, 8'h11, 8'h00);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b1, 8'hFF, 8'h77);
    @(posedge clk); #1;
    drop(1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_rdata", {24'd0, rdata_a}, 32'd0);
    chk("abort_busy",  {31'd0, busy_a},  32'd0);
    chk("abort_hold",  {31'd0, hold_a},  32'd0);
    chk("abort_err",   {31'd0, err_a},   32'd0);
    repeat (5) @(posedge clk);
    req(1'b0, 1'b1, 8'hFF, 8'h00, 8'h11);

    // ADDR/WDATA changes during WAIT do not affect the latched write.
    req(1'b0, 1'b0, 8'h01, 8'h33, 8'h00);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b1, 8'h40, 8'hA5);
    expect_done(1'b0, 1'b0, 8'h00);
    @(posedge clk); #1;
    drop(1'b0);
    ad_a = 8'h01;
    wd_a = 8'h00;
    repeat (5) @(posedge clk);
    req(1'b0, 1'b1, 8'h40, 8'h00, 8'hA5);
    req(1'b0, 1'b1, 8'h01, 8'h00, 8'h33);

    repeat (5) @(posedge clk);
    chk("pending_a", q_a.size(), 32'd0);
    chk("pending_b", q_b.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
